// File: rtl/risc_pkg.sv
// Shared definitions for the issue stage: ALU control codes, issue FSM states
// and the layout of a held issue entry.
package risc_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int SHAMT_W   = 5;
  localparam int CTRL_W    = 4;

  // Bit 3 of the control code makes the ALU shift by shamt instead of op2.
  localparam int CTRL_SHAMT_SEL_BIT = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_COMP = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_DIFF = 4'b0111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs_idx;
    logic [REG_IDX_W-1:0] rt_idx;
    logic [REG_IDX_W-1:0] rd_idx;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic                 use_imm;
    logic [SHAMT_W-1:0]   shamt;
    logic [CTRL_W-1:0]    ctrl;
  } issue_entry_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-side, writeback and ALU-side signals of the issue stage.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the offering side holds its
// payload stable until the transfer happens.
interface ex_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              dec_valid;
  logic              dec_ready;
  logic [IDX_W-1:0]  dec_rs_idx;
  logic [IDX_W-1:0]  dec_rt_idx;
  logic [IDX_W-1:0]  dec_rd_idx;
  logic [DATA_W-1:0] dec_rs_data;
  logic [DATA_W-1:0] dec_rt_data;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_use_imm;
  logic [3:0]        dec_alu_ctrl;
  logic [4:0]        dec_shamt;

  logic              wb_valid;
  logic [IDX_W-1:0]  wb_rd_idx;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] alu_inp1;
  logic [DATA_W-1:0] alu_inp2;
  logic [4:0]        alu_shamt;
  logic [3:0]        alu_ctrl;
  logic [IDX_W-1:0]  ex_rd_idx;

  modport master (
    output dec_valid, dec_rs_idx, dec_rt_idx, dec_rd_idx, dec_rs_data,
           dec_rt_data, dec_imm, dec_use_imm, dec_alu_ctrl, dec_shamt,
           wb_valid, wb_rd_idx, wb_data, ex_ready,
    input  dec_ready, ex_valid, alu_inp1, alu_inp2, alu_shamt, alu_ctrl,
           ex_rd_idx
  );

  modport slave (
    input  dec_valid, dec_rs_idx, dec_rt_idx, dec_rd_idx, dec_rs_data,
           dec_rt_data, dec_imm, dec_use_imm, dec_alu_ctrl, dec_shamt,
           wb_valid, wb_rd_idx, wb_data, ex_ready,
    output dec_ready, ex_valid, alu_inp1, alu_inp2, alu_shamt, alu_ctrl,
           ex_rd_idx
  );
endinterface

// File: rtl/fwd_mux.sv
// Writeback forwarding for a group of operand lanes: a lane takes wb_data when
// it is enabled and its register index matches a nonzero writeback target.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int LANES  = 2
) (
  input  logic [LANES-1:0][IDX_W-1:0]  idx_i,
  input  logic [LANES-1:0][DATA_W-1:0] data_i,
  input  logic [LANES-1:0]             en_i,
  input  logic                         wb_valid_i,
  input  logic [IDX_W-1:0]             wb_rd_idx_i,
  input  logic [DATA_W-1:0]            wb_data_i,
  output logic [LANES-1:0][DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    for (int l = 0; l < LANES; l++) begin
      if (en_i[l] && wb_valid_i && (wb_rd_idx_i != '0) && (idx_i[l] == wb_rd_idx_i)) begin
        data_o[l] = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Registered issue stage in front of the ALU: a MAIN/SKID pair of entries with
// writeback forwarding at capture and while operations are held.
module ex_issue_stage
  import risc_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int IDX_W  = REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  ex_issue_stage_if.slave      bus,
  output issue_state_t         dbg_state_o
);

  issue_state_t state_q, state_d;
  issue_entry_t main_q, main_d, skid_q, skid_d;
  issue_entry_t cap_entry, main_held, skid_held;
  logic         dec_ready_q, dec_ready_d;
  logic         accept, drain;

  logic [DATA_W-1:0]            cap_op2_raw;
  logic [1:0][DATA_W-1:0]       cap_ops, main_ops, skid_ops;

  assign accept = bus.dec_valid & dec_ready_q;
  assign drain  = (state_q != ST_EMPTY) & bus.ex_ready;

  assign cap_op2_raw = bus.dec_use_imm ? bus.dec_imm : bus.dec_rt_data;

  // Lane 0 is op1 (rs), lane 1 is op2 (rt); an immediate op2 is never forwarded.
  fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LANES(2)) u_cap_fwd (
    .idx_i       ({bus.dec_rt_idx, bus.dec_rs_idx}),
    .data_i      ({cap_op2_raw, bus.dec_rs_data}),
    .en_i        ({~bus.dec_use_imm, 1'b1}),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_idx_i (bus.wb_rd_idx),
    .wb_data_i   (bus.wb_data),
    .data_o      (cap_ops)
  );

  fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LANES(2)) u_main_fwd (
    .idx_i       ({main_q.rt_idx, main_q.rs_idx}),
    .data_i      ({main_q.op2, main_q.op1}),
    .en_i        ({~main_q.use_imm, 1'b1}),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_idx_i (bus.wb_rd_idx),
    .wb_data_i   (bus.wb_data),
    .data_o      (main_ops)
  );

  fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W), .LANES(2)) u_skid_fwd (
    .idx_i       ({skid_q.rt_idx, skid_q.rs_idx}),
    .data_i      ({skid_q.op2, skid_q.op1}),
    .en_i        ({~skid_q.use_imm, 1'b1}),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_idx_i (bus.wb_rd_idx),
    .wb_data_i   (bus.wb_data),
    .data_o      (skid_ops)
  );

  always_comb begin
    cap_entry         = '0;
    cap_entry.rs_idx  = bus.dec_rs_idx;
    cap_entry.rt_idx  = bus.dec_rt_idx;
    cap_entry.rd_idx  = bus.dec_rd_idx;
    cap_entry.op1     = cap_ops[0];
    cap_entry.op2     = cap_ops[1];
    cap_entry.use_imm = bus.dec_use_imm;
    cap_entry.shamt   = bus.dec_shamt;
    cap_entry.ctrl    = bus.dec_alu_ctrl;

    main_held     = main_q;
    main_held.op1 = main_ops[0];
    main_held.op2 = main_ops[1];
    skid_held     = skid_q;
    skid_held.op1 = skid_ops[0];
    skid_held.op2 = skid_ops[1];
  end

  // Snooped copies are only written back while the entry is valid, so idle
  // outputs keep their last value.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = cap_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          main_d = main_held;
          if (accept && drain) begin
            main_d = cap_entry;
          end else if (accept) begin
            skid_d  = cap_entry;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          main_d = main_held;
          skid_d = skid_held;
          if (drain) begin
            main_d  = skid_held;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    dec_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      dec_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      dec_ready_q <= dec_ready_d;
    end
  end

  assign bus.dec_ready = dec_ready_q;
  assign bus.ex_valid  = (state_q != ST_EMPTY);
  assign bus.alu_inp1  = main_q.op1;
  assign bus.alu_inp2  = main_q.op2;
  assign bus.alu_shamt = main_q.shamt;
  assign bus.alu_ctrl  = main_q.ctrl;
  assign bus.ex_rd_idx = main_q.rd_idx;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: drivers push expected ALU-side results
// into a queue, a negedge monitor pops and compares on every drain.
module tb_ex_issue_stage;
  import risc_pkg::*;

  localparam int EW = 32 + 32 + 5 + 4 + 5;

  logic clk;
  logic rst_n;
  logic flush;
  issue_state_t dbg_state;

  ex_issue_stage_if #(.DATA_W(32), .IDX_W(5)) bus ();

  ex_issue_stage #(.DATA_W(32), .IDX_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] mon_got, mon_exp;

  function automatic logic [EW-1:0] pack_exp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] sh, input logic [3:0] ct,
                                             input logic [4:0] rd);
    return {a, b, sh, ct, rd};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.ex_valid && bus.ex_ready) begin
      mon_got = {bus.alu_inp1, bus.alu_inp2, bus.alu_shamt, bus.alu_ctrl, bus.ex_rd_idx};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL drain_unexpected: got inp1=%h inp2=%h shamt=%0d ctrl=%b rd=%0d, required none",
                 bus.alu_inp1, bus.alu_inp2, bus.alu_shamt, bus.alu_ctrl, bus.ex_rd_idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL drain_data: got inp1=%h inp2=%h shamt=%0d ctrl=%b rd=%0d, required inp1=%h inp2=%h shamt=%0d ctrl=%b rd=%0d",
                   mon_got[77:46], mon_got[45:14], mon_got[13:9], mon_got[8:5], mon_got[4:0],
                   mon_exp[77:46], mon_exp[45:14], mon_exp[13:9], mon_exp[8:5], mon_exp[4:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic [31:0] imm, input logic use_imm,
                          input logic [3:0] ctrl, input logic [4:0] shamt);
    bus.dec_valid    = 1'b1;
    bus.dec_rs_idx   = rs;
    bus.dec_rt_idx   = rt;
    bus.dec_rd_idx   = rd;
    bus.dec_rs_data  = rs_data;
    bus.dec_rt_data  = rt_data;
    bus.dec_imm      = imm;
    bus.dec_use_imm  = use_imm;
    bus.dec_alu_ctrl = ctrl;
    bus.dec_shamt    = shamt;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] idx, input logic [31:0] data);
    bus.wb_valid  = v;
    bus.wb_rd_idx = idx;
    bus.wb_data   = data;
  endtask

  // Returns just after the edge on which the offered op was taken.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.dec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dec_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got dec_ready=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.dec_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_valid"},  {31'd0, bus.ex_valid},  32'd0);
    chk({tag, "_dec_ready"}, {31'd0, bus.dec_ready}, 32'd1);
    chk({tag, "_inp1"},      bus.alu_inp1,           32'd0);
    chk({tag, "_inp2"},      bus.alu_inp2,           32'd0);
    chk({tag, "_shamt"},     {27'd0, bus.alu_shamt}, 32'd0);
    chk({tag, "_ctrl"},      {28'd0, bus.alu_ctrl},  32'd0);
    chk({tag, "_rd"},        {27'd0, bus.ex_rd_idx}, 32'd0);
    chk({tag, "_state"},     {30'd0, dbg_state},     32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.ex_ready = 1'b0;
    drive_op(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0);
    bus.dec_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Plain ADD with 1-cycle latency, then idle after drain.
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    exp_q.push_back(pack_exp(32'd5, 32'd7, 5'd0, ALU_ADD, 5'd2));
    drive_op(5'd3, 5'd4, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd0);
    wait_accept();
    @(negedge clk);
    chk("add_latency_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_latency_inp1", bus.alu_inp1, 32'd5);
    @(negedge clk);
    chk("add_after_drain_valid", {31'd0, bus.ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Immediate operand ignores a same-cycle writeback to rt.
    exp_q.push_back(pack_exp(32'h11, 32'hFFFF_FFF0, 5'd0, ALU_XOR, 5'd3));
    drive_op(5'd1, 5'd4, 5'd3, 32'h11, 32'h44, 32'hFFFF_FFF0, 1'b1, ALU_XOR, 5'd0);
    set_wb(1'b1, 5'd4, 32'h99);
    wait_accept();

    // Capture-time forwarding on rs, then on rt.
    exp_q.push_back(pack_exp(32'h1234, 32'd2, 5'd0, ALU_ADD, 5'd4));
    drive_op(5'd6, 5'd7, 5'd4, 32'd1, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd0);
    set_wb(1'b1, 5'd6, 32'h1234);
    wait_accept();
    exp_q.push_back(pack_exp(32'd9, 32'h4321, 5'd0, ALU_COMP, 5'd5));
    drive_op(5'd2, 5'd6, 5'd5, 32'd9, 32'd1, 32'd0, 1'b0, ALU_COMP, 5'd0);
    set_wb(1'b1, 5'd6, 32'h4321);
    wait_accept();

    // Writeback to r0 never forwards, even onto a zero index.
    exp_q.push_back(pack_exp(32'd1, 32'd0, 5'd0, ALU_ADD, 5'd6));
    drive_op(5'd6, 5'd0, 5'd6, 32'd1, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd0);
    set_wb(1'b1, 5'd0, 32'h55);
    wait_accept();
    wait_drain();

    // Stall: A in MAIN, B in SKID, C refused; snoop both held entries.
    bus.ex_ready = 1'b0;
    exp_q.push_back(pack_exp(32'hCAFE, 32'd3, 5'd0, ALU_DIFF, 5'd10));
    drive_op(5'd8, 5'd1, 5'd10, 32'h10, 32'd3, 32'd0, 1'b0, ALU_DIFF, 5'd0);
    wait_accept();
    exp_q.push_back(pack_exp(32'hBEEF, 32'd4, 5'd0, ALU_AND, 5'd11));
    drive_op(5'd9, 5'd2, 5'd11, 32'h20, 32'd4, 32'd0, 1'b0, ALU_AND, 5'd0);
    wait_accept();
    exp_q.push_back(pack_exp(32'h77, 32'h100, 5'd7, 4'b1100, 5'd12));
    drive_op(5'd5, 5'd3, 5'd12, 32'h77, 32'd0, 32'h100, 1'b1, 4'b1100, 5'd7);
    set_wb(1'b1, 5'd8, 32'hCAFE);
    @(negedge clk);
    chk("stall_ready_low", {31'd0, bus.dec_ready}, 32'd0);
    chk("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("stall_a_held", bus.alu_inp1, 32'h10);
    chk("stall_state_full", {30'd0, dbg_state}, 32'd2);
    @(posedge clk); #1;
    set_wb(1'b1, 5'd9, 32'hBEEF);
    @(negedge clk);
    chk("snoop_main", bus.alu_inp1, 32'hCAFE);
    chk("stall_ready_still_low", {31'd0, bus.dec_ready}, 32'd0);
    @(posedge clk); #1;
    set_wb(1'b0, 5'd0, 32'd0);
    bus.ex_ready = 1'b1;
    wait_accept();
    wait_drain();

    // Flush in FULL with an op offered: both entries and the offer vanish.
    bus.ex_ready = 1'b0;
    drive_op(5'd1, 5'd2, 5'd20, 32'hD, 32'hD, 32'd0, 1'b0, ALU_ADD, 5'd0);
    wait_accept();
    drive_op(5'd1, 5'd2, 5'd21, 32'hE, 32'hE, 32'd0, 1'b0, ALU_ADD, 5'd0);
    wait_accept();
    drive_op(5'd1, 5'd2, 5'd22, 32'hF, 32'hF, 32'd0, 1'b0, ALU_ADD, 5'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_ready_before", {31'd0, bus.dec_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.dec_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_full_ready", {31'd0, bus.dec_ready}, 32'd1);
    chk("flush_full_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;

    // Flush in ONE while an accept would otherwise happen.
    drive_op(5'd1, 5'd2, 5'd23, 32'h6, 32'h6, 32'd0, 1'b0, ALU_ADD, 5'd0);
    wait_accept();
    drive_op(5'd1, 5'd2, 5'd24, 32'h8, 32'h8, 32'd0, 1'b0, ALU_ADD, 5'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.dec_valid = 1'b0;
    @(negedge clk);
    chk("flush_one_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_one_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    bus.ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_nothing_left", {31'd0, bus.ex_valid}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in FULL clears outputs without a clock edge.
    bus.ex_ready = 1'b0;
    drive_op(5'd3, 5'd4, 5'd25, 32'h123, 32'h456, 32'd0, 1'b0, ALU_SLL, 5'd3);
    wait_accept();
    drive_op(5'd3, 5'd4, 5'd26, 32'h789, 32'hABC, 32'd0, 1'b0, ALU_SRL, 5'd4);
    wait_accept();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset.
    bus.ex_ready = 1'b1;
    exp_q.push_back(pack_exp(32'hAAAA_5555, 32'h0F0F_0F0F, 5'd31, 4'b1110, 5'd31));
    drive_op(5'd13, 5'd14, 5'd31, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'd0, 1'b0, 4'b1110, 5'd31);
    wait_accept();
    wait_drain();
    repeat (2) @(negedge clk);
    chk("final_idle", {31'd0, bus.ex_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
